// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, widths and FSM encoding for the PS/2 key tracker
package ps2_pkg;

  localparam int CODE_W = 9;
  localparam int EVT_W  = 11;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  // E1 is followed by seven more bytes of the pause sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_t;

  // Keyboard status / acknowledge bytes that never carry a key code
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_discard = 1'b1;
      default:                                         is_discard = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - show-ahead event FIFO with synchronous reset
module ps2_evt_fifo #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic              empty,
  output logic [DATA_W-1:0] pop_data
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_pop;
  logic              do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - set-2 scan code decoder, held-key table and event queue
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int EVT_DEPTH      = 8,
  parameter int REPORT_REPEAT  = 0,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_data_en,
  output logic [9*NUM_SLOTS-1:0]    slot_code,
  output logic [NUM_SLOTS-1:0]      slot_valid,
  output logic [CODE_W-1:0]         last_code,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [EVT_W-1:0]          evt_data,
  output logic                      overflow,
  input  logic                      clear_overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          skip_cnt;
  logic [TW-1:0]       tmo_cnt;
  logic                timeout_hit;

  logic                make_en;
  logic                brk_en;
  logic [CODE_W-1:0]   code;

  logic [CODE_W-1:0]   slot_code_r [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] match_vec;
  logic                hit;
  logic                any_free;
  logic [SW-1:0]       free_idx;

  logic                push_en;
  logic [1:0]          push_type;
  logic                fifo_full;
  logic                fifo_empty;
  logic                ovf_make;
  logic                ovf_fifo;

  assign timeout_hit = (state != S_IDLE) && !rx_data_en &&
                       (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rx_data_en) begin
      case (state)
        S_IDLE: begin
          if (rx_data == PS2_EXT)        state_nxt = S_EXT;
          else if (rx_data == PS2_BRK)   state_nxt = S_BRK;
          else if (rx_data == PS2_PAUSE) state_nxt = S_SKIP;
        end
        S_EXT: begin
          if (rx_data == PS2_BRK)        state_nxt = S_EXT_BRK;
          else if (rx_data != PS2_EXT)   state_nxt = S_IDLE;
        end
        S_BRK, S_EXT_BRK:                state_nxt = S_IDLE;
        S_SKIP: if (skip_cnt <= 3'd1)    state_nxt = S_IDLE;
        default:                         state_nxt = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_nxt = S_IDLE;
    end
  end

  always_comb begin
    make_en = 1'b0;
    brk_en  = 1'b0;
    code    = '0;
    if (rx_data_en) begin
      case (state)
        S_IDLE: begin
          if (rx_data != PS2_EXT && rx_data != PS2_BRK &&
              rx_data != PS2_PAUSE && !is_discard(rx_data)) begin
            make_en = 1'b1;
            code    = {1'b0, rx_data};
          end
        end
        S_EXT: begin
          if (rx_data != PS2_BRK && rx_data != PS2_EXT) begin
            make_en = 1'b1;
            code    = {1'b1, rx_data};
          end
        end
        S_BRK: begin
          brk_en = 1'b1;
          code   = {1'b0, rx_data};
        end
        S_EXT_BRK: begin
          brk_en = 1'b1;
          code   = {1'b1, rx_data};
        end
        default: ;
      endcase
    end
  end

  // Timeout counter only runs while a prefix is waiting for its next byte
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      skip_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (state == S_IDLE || rx_data_en) tmo_cnt <= '0;
      else                               tmo_cnt <= tmo_cnt + 1'b1;

      if (rx_data_en) begin
        if (state == S_IDLE && rx_data == PS2_PAUSE) skip_cnt <= PAUSE_SKIP;
        else if (state == S_SKIP && skip_cnt != 3'd0) skip_cnt <= skip_cnt - 1'b1;
      end else if (timeout_hit) begin
        skip_cnt <= '0;
      end
    end
  end

  always_comb begin
    match_vec = '0;
    any_free  = 1'b0;
    free_idx  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      match_vec[i] = slot_valid[i] && (slot_code_r[i] == code);
      if (!slot_valid[i]) begin
        any_free = 1'b1;
        free_idx = SW'(i);
      end
    end
  end

  assign hit = |match_vec;

  always_comb begin
    push_en   = 1'b0;
    push_type = EVT_PRESS;
    ovf_make  = 1'b0;
    if (make_en) begin
      if (hit) begin
        push_en   = (REPORT_REPEAT != 0);
        push_type = EVT_REPEAT;
      end else if (any_free) begin
        push_en   = 1'b1;
        push_type = EVT_PRESS;
      end else begin
        ovf_make  = 1'b1;
      end
    end else if (brk_en && hit) begin
      push_en   = 1'b1;
      push_type = EVT_RELEASE;
    end
  end

  // evt_valid implies non-empty, so a full FIFO only has room when the head is taken
  assign ovf_fifo = push_en && fifo_full && !evt_ready;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      slot_valid <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_code_r[i] <= '0;
      last_code  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (make_en && !hit && any_free) begin
        slot_valid[free_idx]  <= 1'b1;
        slot_code_r[free_idx] <= code;
        last_code             <= code;
      end
      if (brk_en && hit) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (match_vec[i]) begin
            slot_valid[i]  <= 1'b0;
            slot_code_r[i] <= '0;
          end
        end
        if (last_code == code) last_code <= '0;
      end
      overflow <= (overflow && !clear_overflow) || ovf_make || ovf_fifo;
    end
  end

  generate
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
      assign slot_code[9*g +: 9] = slot_code_r[g];
    end
  endgenerate

  ps2_evt_fifo #(
    .DATA_W (EVT_W),
    .DEPTH  (EVT_DEPTH)
  ) u_fifo (
    .clk       (CLOCK_50),
    .reset     (reset),
    .push      (push_en),
    .push_data ({push_type, code}),
    .full      (fifo_full),
    .pop       (evt_ready),
    .empty     (fifo_empty),
    .pop_data  (evt_data)
  );

  assign evt_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - bench for ps2_key_tracker with repeat reporting off and on
module tb_ps2_key_tracker;

  localparam int NS   = 4;
  localparam int DEP  = 8;
  localparam int TMO  = 100;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_en = 1'b0;
  logic        evt_ready = 1'b0;
  logic        clear_overflow = 1'b0;

  logic [9*NS-1:0] sc [2];
  logic [NS-1:0]   sv [2];
  logic [8:0]      lc [2];
  logic            ev [2];
  logic [10:0]     ed [2];
  logic            of [2];

  int checks = 0;
  int failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_key_tracker #(.NUM_SLOTS(NS), .EVT_DEPTH(DEP), .REPORT_REPEAT(0), .TIMEOUT_CYCLES(TMO)) dut0 (
    .CLOCK_50(CLOCK_50), .reset(reset), .rx_data(rx_data), .rx_data_en(rx_data_en),
    .slot_code(sc[0]), .slot_valid(sv[0]), .last_code(lc[0]), .evt_valid(ev[0]),
    .evt_ready(evt_ready), .evt_data(ed[0]), .overflow(of[0]), .clear_overflow(clear_overflow));

  ps2_key_tracker #(.NUM_SLOTS(NS), .EVT_DEPTH(DEP), .REPORT_REPEAT(1), .TIMEOUT_CYCLES(TMO)) dut1 (
    .CLOCK_50(CLOCK_50), .reset(reset), .rx_data(rx_data), .rx_data_en(rx_data_en),
    .slot_code(sc[1]), .slot_valid(sv[1]), .last_code(lc[1]), .evt_valid(ev[1]),
    .evt_ready(evt_ready), .evt_data(ed[1]), .overflow(of[1]), .clear_overflow(clear_overflow));

  // Reference model: decoder position plus per-DUT set of held keys and event list
  int         d_st;     // 0 idle, 1 after E0, 2 after F0, 3 after E0 F0
  int         d_skip;
  int         d_gap;
  logic [8:0] m_code [2][NS];
  bit         m_val  [2][NS];
  logic [8:0] m_last [2];
  logic [10:0] mq    [2][DEP];
  int         mcnt   [2];
  bit         m_ovf  [2];

  task automatic model_reset();
    d_st = 0; d_skip = 0; d_gap = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NS; i++) begin m_code[r][i] = '0; m_val[r][i] = 0; end
      m_last[r] = '0; mcnt[r] = 0; m_ovf[r] = 0;
    end
  endtask

  function automatic bit discard_byte(input logic [7:0] b);
    return (b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
            b == 8'hFC || b == 8'hFE || b == 8'hFF);
  endfunction

  task automatic model_edge();
    bit mk, bk, nov, psh, pop;
    logic [8:0] c;
    logic [1:0] ty;
    int idx, fr;
    mk = 0; bk = 0; c = '0;
    if (rx_data_en) begin
      d_gap = 0;
      if (d_skip > 0) d_skip--;
      else case (d_st)
        0: if (rx_data == 8'hE0) d_st = 1;
           else if (rx_data == 8'hF0) d_st = 2;
           else if (rx_data == 8'hE1) d_skip = 7;
           else if (!discard_byte(rx_data)) begin mk = 1; c = {1'b0, rx_data}; end
        1: if (rx_data == 8'hF0) d_st = 3;
           else if (rx_data != 8'hE0) begin mk = 1; c = {1'b1, rx_data}; d_st = 0; end
        2: begin bk = 1; c = {1'b0, rx_data}; d_st = 0; end
        default: begin bk = 1; c = {1'b1, rx_data}; d_st = 0; end
      endcase
    end else if (d_st != 0 || d_skip > 0) begin
      d_gap++;
      if (d_gap == TMO) begin d_st = 0; d_skip = 0; d_gap = 0; end
    end
    for (int r = 0; r < 2; r++) begin
      pop = evt_ready && (mcnt[r] > 0);
      if (pop) begin
        for (int k = 0; k < DEP - 1; k++) mq[r][k] = mq[r][k+1];
        mcnt[r]--;
      end
      nov = 0; psh = 0; ty = 2'b00;
      idx = -1; fr = -1;
      for (int i = 0; i < NS; i++) if (m_val[r][i] && m_code[r][i] == c) idx = i;
      for (int i = NS - 1; i >= 0; i--) if (!m_val[r][i]) fr = i;
      if (mk) begin
        if (idx >= 0) begin psh = (r == 1); ty = 2'b11; end
        else if (fr >= 0) begin
          m_val[r][fr] = 1; m_code[r][fr] = c; m_last[r] = c; psh = 1; ty = 2'b01;
        end else nov = 1;
      end
      if (bk && idx >= 0) begin
        m_val[r][idx] = 0; m_code[r][idx] = '0; psh = 1; ty = 2'b10;
        if (m_last[r] == c) m_last[r] = '0;
      end
      if (psh) begin
        if (mcnt[r] < DEP) begin mq[r][mcnt[r]] = {ty, c}; mcnt[r]++; end
        else nov = 1;
      end
      m_ovf[r] = (m_ovf[r] && !clear_overflow) || nov;
    end
  endtask

  task automatic chk(input string tag, input int r, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, r, got, exp);
    end
  endtask

  task automatic check_all();
    logic [9*NS-1:0] esc;
    logic [NS-1:0]   esv;
    for (int r = 0; r < 2; r++) begin
      esc = '0; esv = '0;
      for (int i = 0; i < NS; i++) begin
        esv[i] = m_val[r][i];
        esc[9*i +: 9] = m_val[r][i] ? m_code[r][i] : 9'h000;
      end
      chk("slot_valid", r, 64'(sv[r]), 64'(esv));
      chk("slot_code",  r, 64'(sc[r]), 64'(esc));
      chk("last_code",  r, 64'(lc[r]), 64'(m_last[r]));
      chk("evt_valid",  r, 64'(ev[r]), 64'(mcnt[r] > 0));
      chk("evt_data",   r, 64'(ed[r]), (mcnt[r] > 0) ? 64'(mq[r][0]) : 64'h0);
      chk("overflow",   r, 64'(of[r]), 64'(m_ovf[r]));
    end
  endtask

  task automatic tick(input bit en, input logic [7:0] b, input bit rdy, input bit clr);
    rx_data_en = en; rx_data = b; evt_ready = rdy; clear_overflow = clr;
    @(posedge CLOCK_50);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    tick(1'b1, b, rdy, 1'b0);
    tick(1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_data_en = 1'b0; evt_ready = 1'b0; clear_overflow = 1'b0;
    @(posedge CLOCK_50);
    model_reset();
    #1;
    reset = 1'b0;
    check_all();
  endtask

  logic [7:0] pool [7] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h75, 8'h6B};

  initial begin
    logic [7:0] b;
    int p;
    model_reset();
    do_reset();
    chk("reset_evt_data", 0, 64'(ed[0]), 64'h0);
    chk("reset_slot_valid", 1, 64'(sv[1]), 64'h0);

    send(8'h1C, 1'b0);
    chk("a_press_last", 0, 64'(lc[0]), 64'h01C);
    chk("a_press_evt", 0, 64'(ed[0]), 64'h21C);
    idle(2, 1'b1);
    send(8'hF0, 1'b1); send(8'h1C, 1'b1);
    chk("a_release_valid", 0, 64'(sv[0]), 64'h0);

    send(8'hE0, 1'b0); send(8'h75, 1'b0);
    chk("up_press_evt", 1, 64'(ed[1]), 64'h375);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
    idle(3, 1'b1);

    foreach (pool[i]) if (i < 5) send(pool[i], 1'b1);
    chk("table_full_ovf", 0, 64'(of[0]), 64'h1);
    tick(1'b0, 8'h00, 1'b1, 1'b1);
    chk("ovf_cleared", 0, 64'(of[0]), 64'h0);
    for (int i = 0; i < 4; i++) begin send(8'hF0, 1'b1); send(pool[i], 1'b1); end

    for (int i = 0; i < 3; i++) send(8'h1C, 1'b0);
    idle(4, 1'b1);
    send(8'hF0, 1'b1); send(8'h1C, 1'b1);

    foreach (pool[i]) if (i < 1) ;
    send(8'hE1, 1'b1); send(8'h14, 1'b1); send(8'h77, 1'b1); send(8'hE1, 1'b1);
    send(8'hF0, 1'b1); send(8'h14, 1'b1); send(8'hF0, 1'b1); send(8'h77, 1'b1);
    send(8'h1C, 1'b0);
    chk("after_pause_last", 0, 64'(lc[0]), 64'h01C);
    idle(2, 1'b1);
    send(8'hF0, 1'b1); send(8'h1C, 1'b1);

    // eight events queued, ninth pushed alongside a pop, then a true overflow
    for (int i = 0; i < 4; i++) send(pool[i], 1'b0);
    for (int i = 0; i < 4; i++) begin send(8'hF0, 1'b0); send(pool[i], 1'b0); end
    tick(1'b1, 8'h1C, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    send(8'h1B, 1'b0);
    chk("fifo_full_ovf", 0, 64'(of[0]), 64'h1);
    idle(10, 1'b1);
    send(8'hF0, 1'b1); send(8'h1C, 1'b1);
    send(8'hF0, 1'b1); send(8'h1B, 1'b1);

    send(8'hE0, 1'b1);
    idle(TMO + 20, 1'b1);
    send(8'h1C, 1'b1);
    chk("timeout_last", 0, 64'(lc[0]), 64'h01C);
    send(8'hF0, 1'b1); send(8'h1C, 1'b1);

    send(8'hE0, 1'b1); send(8'hF0, 1'b1);
    do_reset();
    send(8'h1C, 1'b1);
    chk("reset_mid_last", 1, 64'(lc[1]), 64'h01C);

    for (int n = 0; n < 600; n++) begin
      p = $urandom_range(0, 99);
      if (p < 60)      b = pool[$urandom_range(0, 6)];
      else if (p < 78) b = 8'hF0;
      else if (p < 93) b = 8'hE0;
      else if (p < 97) b = 8'hAA;
      else             b = 8'hE1;
      tick($urandom_range(0, 1) == 1, b, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    idle(12, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
